// File: rtl/mp_addsub_seq.sv
// mp_addsub_seq: limb-serial multi-precision adder/subtractor with an optional
// right shift by one of the (WIDTH+1)-bit result.
//
// Ports:
//   clk       rising-edge clock
//   resetn    asynchronous active-low reset
//   start     operation request, accepted in IDLE and DONE
//   subtract  0: a+b, 1: a-b (latched with start)
//   shift     1: result is right-shifted by one (latched with start)
//   in_a      operand A, WIDTH bits (latched with start)
//   in_b      operand B, WIDTH bits (latched with start)
//   result    registered WIDTH+1 bit result, held until the next completion
//   carry     carry out of bit WIDTH-1; for subtract, 1 iff a >= b
//   busy      high while the limb loop runs
//   done      one-cycle completion pulse
module mp_addsub_seq #(
    parameter int unsigned WIDTH = 514,
    parameter int unsigned LIMB  = 128
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic             shift,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NLIMB = (WIDTH + LIMB - 1) / LIMB;
    localparam int unsigned EXTW  = NLIMB * LIMB;
    // Number of meaningful bits in the most significant limb.
    localparam int unsigned TOPW  = WIDTH - (NLIMB - 1) * LIMB;
    localparam int unsigned CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam int unsigned SW    = LIMB + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [EXTW-1:0] a_sr;
    logic [EXTW-1:0] b_sr;
    logic [EXTW-1:0] acc_q;
    logic [EXTW-1:0] acc_nxt;
    logic [EXTW-1:0] a_ext;
    logic [EXTW-1:0] b_ext;
    logic [LIMB-1:0] a_l;
    logic [LIMB-1:0] b_l;
    logic [LIMB:0]   s;
    logic            c_q;
    logic            sub_q;
    logic            shift_q;
    logic            co;
    logic            accept;
    logic            last;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH:0]  r_full;

    // Operand capture: zero-extend first, then invert B for subtraction.
    assign a_ext  = EXTW'(in_a);
    assign b_ext  = EXTW'(in_b) ^ {EXTW{subtract}};

    assign accept = start && (state_q != ST_CALC);
    assign last   = (cnt_q == CW'(NLIMB - 1));

    // Operands shift down one limb per cycle, so the current limb is always at the bottom.
    assign a_l    = a_sr[LIMB-1:0];
    assign b_l    = b_sr[LIMB-1:0];
    assign s      = SW'(a_l) + SW'(b_l) + SW'(c_q);

    // Accumulator fills from the top; after NLIMB limbs limb 0 sits at the LSB.
    assign acc_nxt = EXTW'({s[LIMB-1:0], acc_q} >> LIMB);

    // Carry out of bit WIDTH-1: either the limb carry, or the carry into bit TOPW
    // of the last limb recovered from its sum bit.
    if (TOPW == LIMB) begin : g_co_full
        assign co = s[LIMB];
    end else begin : g_co_part
        assign co = s[TOPW] ^ a_l[TOPW] ^ b_l[TOPW];
    end

    assign r_full = {co ^ sub_q, acc_nxt[WIDTH-1:0]};

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_CALC;
            ST_CALC: if (last)  state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_CALC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_sr    <= '0;
            b_sr    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            shift_q <= 1'b0;
            cnt_q   <= '0;
            result  <= '0;
            carry   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_d == ST_CALC);
            done <= (state_d == ST_DONE);
            if (accept) begin
                a_sr    <= a_ext;
                b_sr    <= b_ext;
                sub_q   <= subtract;
                shift_q <= shift;
                c_q     <= subtract;
                cnt_q   <= '0;
            end else if (state_q == ST_CALC) begin
                a_sr  <= a_sr >> LIMB;
                b_sr  <= b_sr >> LIMB;
                acc_q <= acc_nxt;
                c_q   <= s[LIMB];
                cnt_q <= cnt_q + CW'(1);
                if (last) begin
                    result <= shift_q ? {1'b0, r_full[WIDTH:1]} : r_full;
                    carry  <= co;
                end
            end
        end
    end

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Self-checking bench for mp_addsub_seq: a 514/128 instance and a 20/8 instance,
// fixed vectors, multi-cycle corner sequences and randomized operations checked
// against an arithmetic reference model.
module tb_mp_addsub_seq;

    localparam int NL0 = 5;
    localparam int NL1 = 3;

    logic         clk;
    logic         resetn;

    logic         start0, sub0, sh0;
    logic [513:0] a0, b0;
    logic [514:0] res0;
    logic         cy0, busy0, done0;

    logic         start1, sub1, sh1;
    logic [19:0]  a1, b1;
    logic [20:0]  res1;
    logic         cy1, busy1, done1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int           inst;
        bit           sub;
        bit           sh;
        logic [513:0] a;
        logic [513:0] b;
        logic [514:0] er;
        bit           ec;
    } vec_t;

    vec_t tv[10];

    mp_addsub_seq #(.WIDTH(514), .LIMB(128)) u_big (
        .clk(clk), .resetn(resetn), .start(start0), .subtract(sub0), .shift(sh0),
        .in_a(a0), .in_b(b0), .result(res0), .carry(cy0), .busy(busy0), .done(done0)
    );

    mp_addsub_seq #(.WIDTH(20), .LIMB(8)) u_small (
        .clk(clk), .resetn(resetn), .start(start1), .subtract(sub1), .shift(sh1),
        .in_a(a1), .in_b(b1), .result(res1), .carry(cy1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [514:0] act, input logic [514:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int inst, input bit sub, input bit sh,
                                input logic [513:0] a, input logic [513:0] b,
                                input logic [514:0] er, input bit ec);
        vec_t v;
        v.inst = inst; v.sub = sub; v.sh = sh; v.a = a; v.b = b; v.er = er; v.ec = ec;
        return v;
    endfunction

    function automatic logic [513:0] rand_wide();
        logic [513:0] r;
        r = '0;
        for (int i = 0; i < 17; i++) r = (r << 32) | 514'($urandom);
        return r;
    endfunction

    function automatic logic [513:0] pick();
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0:       return '0;
            1:       return '1;
            2:       return 514'($urandom_range(0, 3));
            default: return rand_wide();
        endcase
    endfunction

    // Reference: plain (w+1)-bit arithmetic on the masked operands.
    function automatic logic [514:0] model(input int w, input bit sub, input bit sh,
                                           input logic [513:0] a_in, input logic [513:0] b_in,
                                           output logic cy);
        logic [514:0] m, a, b, r;
        m = (515'(1) << w) - 515'(1);
        a = 515'(a_in) & m;
        b = 515'(b_in) & m;
        r = sub ? (a - b) : (a + b);
        r = r & ((m << 1) | 515'(1));
        cy = sub ? (a >= b) : r[w];
        return sh ? (r >> 1) : r;
    endfunction

    function automatic logic cur_done(input int inst);
        return (inst == 0) ? done0 : done1;
    endfunction

    function automatic logic cur_busy(input int inst);
        return (inst == 0) ? busy0 : busy1;
    endfunction

    // One operation: drive start for one edge, scramble inputs afterwards, wait for done.
    task automatic run_op(input int inst, input bit sub, input bit sh,
                          input logic [513:0] a, input logic [513:0] b,
                          output logic [514:0] res, output logic cy, output int lat,
                          output int bcnt, output logic busy_end, output logic done_after);
        @(negedge clk);
        if (inst == 0) begin
            a0 = a; b0 = b; sub0 = sub; sh0 = sh; start0 = 1'b1;
        end else begin
            a1 = a[19:0]; b1 = b[19:0]; sub1 = sub; sh1 = sh; start1 = 1'b1;
        end
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        a0 = rand_wide(); b0 = rand_wide(); sub0 = ~sub; sh0 = ~sh;
        a1 = 20'($urandom); b1 = 20'($urandom); sub1 = ~sub; sh1 = ~sh;
        lat = 0;
        bcnt = 0;
        while (!cur_done(inst) && lat < 40) begin
            if (cur_busy(inst)) bcnt++;
            @(negedge clk);
            lat++;
        end
        res = (inst == 0) ? res0 : 515'(res1);
        cy = (inst == 0) ? cy0 : cy1;
        busy_end = cur_busy(inst);
        @(negedge clk);
        done_after = cur_done(inst);
    endtask

    logic [514:0] got_res, exp_res, first_res, r1;
    logic         got_cy, exp_cy, busy_end, done_after;
    int           lat, bcnt, pulses, t1, t2, n, nl, inst;
    bit           rsub, rsh;
    logic [513:0] ra, rb;

    initial begin
        tv[0] = mk(0, 0, 0, '1, 514'd1, 515'(1) << 514, 1);
        tv[1] = mk(0, 1, 0, 514'd5, 514'd7, {{514{1'b1}}, 1'b0}, 0);
        tv[2] = mk(0, 1, 0, 514'd7, 514'd5, 515'd2, 1);
        tv[3] = mk(0, 0, 1, 514'd3, 514'd4, 515'd3, 0);
        tv[4] = mk(0, 1, 1, 514'd5, 514'd7, {1'b0, {514{1'b1}}}, 0);
        tv[5] = mk(0, 0, 0, (514'(1) << 384) - 514'(1), 514'd1, 515'(1) << 384, 0);
        tv[6] = mk(1, 0, 0, 514'hFFFFF, 514'd1, 515'h100000, 1);
        tv[7] = mk(1, 1, 0, 514'd0, 514'd0, 515'd0, 1);
        tv[8] = mk(1, 1, 1, 514'd0, 514'd1, 515'hFFFFF, 0);
        tv[9] = mk(1, 0, 1, 514'hFFFFF, 514'hFFFFF, 515'hFFFFF, 1);

        start0 = 0; sub0 = 0; sh0 = 0; a0 = '0; b0 = '0;
        start1 = 0; sub1 = 0; sh1 = 0; a1 = '0; b1 = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2;
        check("reset result0", res0, '0);
        check("reset ctl0", {512'd0, cy0, busy0, done0}, '0);
        check("reset result1", 515'(res1), '0);
        check("reset ctl1", {512'd0, cy1, busy1, done1}, '0);
        @(negedge clk);
        resetn = 1'b1;

        // Fixed vectors.
        for (int i = 0; i < 10; i++) begin
            nl = (tv[i].inst == 0) ? NL0 : NL1;
            run_op(tv[i].inst, tv[i].sub, tv[i].sh, tv[i].a, tv[i].b,
                   got_res, got_cy, lat, bcnt, busy_end, done_after);
            check($sformatf("vec%0d result", i), got_res, tv[i].er);
            check($sformatf("vec%0d carry", i), 515'(got_cy), 515'(tv[i].ec));
            check($sformatf("vec%0d latency", i), 515'(lat), 515'(nl));
            check($sformatf("vec%0d busy cycles", i), 515'(bcnt), 515'(nl));
            check($sformatf("vec%0d busy at done", i), 515'(busy_end), '0);
            check($sformatf("vec%0d done width", i), 515'(done_after), '0);
        end

        // start pulsed during CALC must be ignored.
        @(negedge clk);
        a0 = (514'(1) << 384) - 514'(1); b0 = 514'd1; sub0 = 0; sh0 = 0; start0 = 1;
        @(negedge clk);
        start0 = 0;
        @(negedge clk);
        a0 = rand_wide(); b0 = rand_wide(); sub0 = 1; sh0 = 1; start0 = 1;
        @(negedge clk);
        start0 = 0;
        pulses = 0;
        first_res = '0;
        for (int i = 0; i < 15; i++) begin
            if (done0) begin
                pulses++;
                if (pulses == 1) first_res = res0;
            end
            @(negedge clk);
        end
        check("ignore start done pulses", 515'(pulses), 515'd1);
        check("ignore start result", first_res, 515'(1) << 384);
        check("result held", res0, 515'(1) << 384);

        // start held high: back-to-back operations on the small instance.
        @(negedge clk);
        a1 = 20'hFFFFF; b1 = 20'h00001; sub1 = 0; sh1 = 0; start1 = 1;
        t1 = -1; t2 = -1; n = 0; r1 = '0;
        while (n < 40 && t2 < 0) begin
            @(negedge clk);
            n++;
            if (done1) begin
                if (t1 < 0) begin
                    t1 = n;
                    r1 = 515'(res1);
                    a1 = 20'h12345; b1 = 20'h00ABC; sub1 = 1;
                end else begin
                    t2 = n;
                end
            end else if (t1 >= 0) begin
                start1 = 0;
                a1 = 20'($urandom); b1 = 20'($urandom); sub1 = 0;
            end
        end
        start1 = 0;
        check("held first done time", 515'(t1), 515'(NL1 + 1));
        check("held first result", r1, 515'h100000);
        check("held done spacing", 515'(t2 - t1), 515'(NL1 + 1));
        check("held second result", 515'(res1), 515'h11889);
        check("held second carry", 515'(cy1), 515'd1);

        // Reset in the middle of an operation.
        @(negedge clk);
        a0 = 514'd9; b0 = 514'd3; sub0 = 0; sh0 = 0; start0 = 1;
        @(negedge clk);
        start0 = 0;
        @(negedge clk);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("mid reset result", res0, '0);
        check("mid reset ctl", {512'd0, cy0, busy0, done0}, '0);
        @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done0) pulses++;
            @(negedge clk);
        end
        check("no done after reset", 515'(pulses), '0);
        run_op(0, 0, 0, 514'd1, 514'd1, got_res, got_cy, lat, bcnt, busy_end, done_after);
        check("post reset result", got_res, 515'd2);
        check("post reset latency", 515'(lat), 515'(NL0));

        // Randomized operations against the model.
        for (int i = 0; i < 60; i++) begin
            inst = i % 2;
            rsub = 1'($urandom_range(0, 1));
            rsh = 1'($urandom_range(0, 1));
            ra = pick();
            rb = ($urandom_range(0, 7) == 0) ? ra : pick();
            exp_res = model((inst == 0) ? 514 : 20, rsub, rsh, ra, rb, exp_cy);
            run_op(inst, rsub, rsh, ra, rb, got_res, got_cy, lat, bcnt, busy_end, done_after);
            check($sformatf("rand%0d result", i), got_res, exp_res);
            check($sformatf("rand%0d carry", i), 515'(got_cy), 515'(exp_cy));
            check($sformatf("rand%0d latency", i), 515'(lat), 515'((inst == 0) ? NL0 : NL1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
